// File: rtl/bram_512x32_dp.sv
// ---------------------------------------------------------------------------
// bram_512x32_dp
//
// True dual-port synchronous SRAM macro model: DEPTH words x DATA_WIDTH bits,
// two fully independent read/write ports sharing one clock. This is the leaf
// storage element tiled by the multi-port memory wrappers.
//
// Ports (p = 0 or 1):
//   CLK      clock; every state change happens on the rising edge
//   RESETN   synchronous active-low reset; clears Q0/Q1 and blocks all writes
//   CEp      port enable; 0 = no access, Qp holds its value
//   Ap       word address
//   Dp       write data
//   WEp      write enable, only honoured while CEp = 1
//   WEMp     per-bit write mask, 1 = write this bit
//   Qp       registered read data, one cycle after an enabled access
//
// Semantics:
//   - Reads are read-first: Q returns the word as it was before the edge,
//     even when either port writes the same address in that cycle.
//   - When both ports write the same word, bits enabled by only one port
//     take that port's data and bits enabled by both take port 1's data.
//   - Storage is not cleared by reset. DEPTH must equal 2**ADDR_WIDTH.
// ---------------------------------------------------------------------------
module bram_512x32_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  CE0,
    input  logic [ADDR_WIDTH-1:0] A0,
    input  logic [DATA_WIDTH-1:0] D0,
    input  logic                  WE0,
    input  logic [DATA_WIDTH-1:0] WEM0,
    output logic [DATA_WIDTH-1:0] Q0,
    input  logic                  CE1,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [DATA_WIDTH-1:0] D1,
    input  logic                  WE1,
    input  logic [DATA_WIDTH-1:0] WEM1,
    output logic [DATA_WIDTH-1:0] Q1
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [DATA_WIDTH-1:0] q0_reg;
    logic [DATA_WIDTH-1:0] q1_reg;

    logic                  wr0;
    logic                  wr1;
    logic                  same_word_write;
    logic [DATA_WIDTH-1:0] old0;
    logic [DATA_WIDTH-1:0] old1;
    logic [DATA_WIDTH-1:0] merge1_base;
    logic [DATA_WIDTH-1:0] word0_next;
    logic [DATA_WIDTH-1:0] word1_next;

    always_comb begin
        wr0             = CE0 && WE0;
        wr1             = CE1 && WE1;
        same_word_write = wr0 && wr1 && (A0 == A1);
        old0            = mem[A0];
        old1            = mem[A1];
        // When both ports hit the same word, port 1 merges on top of port 0's
        // result so bits enabled only by port 0 survive and port 1 wins the
        // bits both ports enable. Port 1's store is issued last and carries
        // the fully merged word.
        merge1_base     = same_word_write ? word0_next : old1;
    end

    // Per-bit masked merge for each port.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_merge
            assign word0_next[gi] = WEM0[gi] ? D0[gi] : old0[gi];
            assign word1_next[gi] = WEM1[gi] ? D1[gi] : merge1_base[gi];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            q0_reg <= '0;
            q1_reg <= '0;
        end else begin
            // Read-first: Q samples the word before this edge's writes land.
            if (CE0) begin
                q0_reg <= old0;
            end
            if (CE1) begin
                q1_reg <= old1;
            end
            if (wr0) begin
                mem[A0] <= word0_next;
            end
            // Ordered after port 0 so the merged word wins a same-address write.
            if (wr1) begin
                mem[A1] <= word1_next;
            end
        end
    end

    assign Q0 = q0_reg;
    assign Q1 = q1_reg;

endmodule

// File: tb/tb_bram_512x32_dp.sv
// ---------------------------------------------------------------------------
// tb_bram_512x32_dp
//
// Self-checking bench for bram_512x32_dp. A table of directed vectors covers
// reset, latency/hold, bit masking, read-first and dual-port same-word writes;
// a random phase checks both ports against a reference array model.
// Expected Q values are queued when a cycle is driven and popped/compared
// just after the clock edge that produces them.
// ---------------------------------------------------------------------------
module tb_bram_512x32_dp;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] Z32  = 32'h0;
    localparam logic [8:0]  Z9   = 9'd0;
    localparam bit          Y    = 1'b1;
    localparam bit          N    = 1'b0;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ce0, we0, ce1, we1;
    logic [8:0]  a0, a1;
    logic [31:0] d0, wem0, d1, wem1;
    logic [31:0] q0, q1;

    always #5 clk = ~clk;

    bram_512x32_dp dut (
        .CLK    (clk),
        .RESETN (resetn),
        .CE0    (ce0),
        .A0     (a0),
        .D0     (d0),
        .WE0    (we0),
        .WEM0   (wem0),
        .Q0     (q0),
        .CE1    (ce1),
        .A1     (a1),
        .D1     (d1),
        .WE1    (we1),
        .WEM1   (wem1),
        .Q1     (q1)
    );

    typedef struct {
        bit          rst_n;
        bit          ce0;
        bit          we0;
        logic [8:0]  a0;
        logic [31:0] d0;
        logic [31:0] wem0;
        bit          ce1;
        bit          we1;
        logic [8:0]  a1;
        logic [31:0] d1;
        logic [31:0] wem1;
        bit          chk0;
        logic [31:0] exp0;
        bit          chk1;
        logic [31:0] exp1;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [0:511];
    logic [31:0] ref_q0;
    logic [31:0] ref_q1;
    int          total = 0;
    int          bad   = 0;

    function automatic vec_t mk(
        input bit rst_n,
        input bit c0, input bit w0, input logic [8:0] ad0,
        input logic [31:0] dd0, input logic [31:0] m0,
        input bit c1, input bit w1, input logic [8:0] ad1,
        input logic [31:0] dd1, input logic [31:0] m1,
        input bit k0, input logic [31:0] e0,
        input bit k1, input logic [31:0] e1);
        vec_t v;
        v.rst_n = rst_n;
        v.ce0 = c0; v.we0 = w0; v.a0 = ad0; v.d0 = dd0; v.wem0 = m0;
        v.ce1 = c1; v.we1 = w1; v.a1 = ad1; v.d1 = dd1; v.wem1 = m1;
        v.chk0 = k0; v.exp0 = e0; v.chk1 = k1; v.exp1 = e1;
        return v;
    endfunction

    // Reference behaviour: read-first, port 1 applied after port 0 per bit.
    task automatic model_step(input vec_t v);
        logic [31:0] old0;
        logic [31:0] old1;
        old0 = ref_mem[v.a0];
        old1 = ref_mem[v.a1];
        if (!v.rst_n) begin
            ref_q0 = Z32;
            ref_q1 = Z32;
        end else begin
            if (v.ce0) ref_q0 = old0;
            if (v.ce1) ref_q1 = old1;
            if (v.ce0 && v.we0)
                for (int b = 0; b < 32; b++)
                    if (v.wem0[b]) ref_mem[v.a0][b] = v.d0[b];
            if (v.ce1 && v.we1)
                for (int b = 0; b < 32; b++)
                    if (v.wem1[b]) ref_mem[v.a1][b] = v.d1[b];
        end
    endtask

    // Drive one cycle, queue expectations, clock it, then check outputs.
    task automatic run_vec(input vec_t v, input string name, input bit use_model);
        exp_t e;
        logic [31:0] got;
        @(negedge clk);
        resetn = v.rst_n;
        ce0 = v.ce0; we0 = v.we0; a0 = v.a0; d0 = v.d0; wem0 = v.wem0;
        ce1 = v.ce1; we1 = v.we1; a1 = v.a1; d1 = v.d1; wem1 = v.wem1;
        model_step(v);
        if (use_model) begin
            sb_q.push_back('{port: 0, exp: ref_q0});
            sb_q.push_back('{port: 1, exp: ref_q1});
        end else begin
            if (v.chk0) sb_q.push_back('{port: 0, exp: v.exp0});
            if (v.chk1) sb_q.push_back('{port: 1, exp: v.exp1});
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = (e.port == 1) ? q1 : q0;
            total++;
            if (got !== e.exp) begin
                bad++;
                $display("FAIL %s Q%0d got=%08h want=%08h", name, e.port, got, e.exp);
            end else begin
                $display("ok   %s Q%0d = %08h", name, e.port, got);
            end
        end
    endtask

    vec_t tbl [25];

    initial begin
        vec_t v;

        for (int i = 0; i < 512; i++) ref_mem[i] = Z32;
        ref_q0 = Z32;
        ref_q1 = Z32;
        resetn = 1'b0;
        ce0 = 1'b0; we0 = 1'b0; a0 = Z9; d0 = Z32; wem0 = Z32;
        ce1 = 1'b0; we1 = 1'b0; a1 = Z9; d1 = Z32; wem1 = Z32;

        // Initial reset, then clear every word so contents are known.
        for (int i = 0; i < 2; i++)
            run_vec(mk(N, N,N,Z9,Z32,Z32, N,N,Z9,Z32,Z32, Y,Z32, Y,Z32), "init_rst", 1'b0);
        for (int i = 0; i < 256; i++) begin
            v = mk(Y, Y,Y,9'(2*i),Z32,ONES, Y,Y,9'(2*i+1),Z32,ONES, N,Z32, N,Z32);
            run_vec(v, "fill", 1'b0);
        end

        // Directed table: expected values are Q after each edge.
        tbl[0]  = mk(Y, Y,Y,9'd9,32'hC3C3C3C3,ONES, N,N,Z9,Z32,Z32, Y,Z32, N,Z32);
        tbl[1]  = mk(Y, Y,N,9'd9,Z32,Z32, Y,N,9'd9,Z32,Z32, Y,32'hC3C3C3C3, Y,32'hC3C3C3C3);
        tbl[2]  = mk(N, Y,Y,9'd5,ONES,ONES, Y,N,9'd5,Z32,Z32, Y,Z32, Y,Z32);
        tbl[3]  = mk(N, Y,Y,9'd5,ONES,ONES, Y,N,9'd5,Z32,Z32, Y,Z32, Y,Z32);
        tbl[4]  = mk(Y, Y,N,9'd5,Z32,Z32, N,N,Z9,Z32,Z32, Y,Z32, Y,Z32);
        tbl[5]  = mk(Y, Y,Y,9'h1FF,32'hDEADBEEF,ONES, N,N,Z9,Z32,Z32, Y,Z32, N,Z32);
        tbl[6]  = mk(Y, N,N,Z9,Z32,Z32, Y,N,9'h1FF,Z32,Z32, N,Z32, Y,32'hDEADBEEF);
        for (int i = 7; i <= 11; i++)
            tbl[i] = mk(Y, N,N,Z9,Z32,Z32, N,Y,9'd3,ONES,ONES, N,Z32, Y,32'hDEADBEEF);
        tbl[12] = mk(Y, Y,Y,9'd3,ONES,ONES, N,N,Z9,Z32,Z32, N,Z32, N,Z32);
        tbl[13] = mk(Y, Y,Y,9'd3,Z32,32'h0000FFFF, N,N,Z9,Z32,Z32, Y,ONES, N,Z32);
        tbl[14] = mk(Y, Y,Y,9'd3,32'h12345678,32'h000000F0, N,N,Z9,Z32,Z32, Y,32'hFFFF0000, N,Z32);
        tbl[15] = mk(Y, N,N,Z9,Z32,Z32, Y,N,9'd3,Z32,Z32, N,Z32, Y,32'hFFFF0070);
        tbl[16] = mk(Y, Y,Y,9'd7,32'hAAAA5555,ONES, N,N,Z9,Z32,Z32, N,Z32, N,Z32);
        tbl[17] = mk(Y, Y,Y,9'd7,32'h11111111,ONES, Y,N,9'd7,Z32,Z32, Y,32'hAAAA5555, Y,32'hAAAA5555);
        tbl[18] = mk(Y, N,N,Z9,Z32,Z32, Y,N,9'd7,Z32,Z32, Y,32'hAAAA5555, Y,32'h11111111);
        tbl[19] = mk(Y, Y,Y,9'd100,32'h0F0F0F0F,32'hFFFF0000, Y,Y,9'd100,32'hF0F0F0F0,32'h00FFFF00, Y,Z32, Y,Z32);
        tbl[20] = mk(Y, Y,N,9'd100,Z32,Z32, Y,N,9'd100,Z32,Z32, Y,32'h0FF0F000, Y,32'h0FF0F000);
        tbl[21] = mk(Y, Y,Y,9'd100,ONES,Z32, N,N,Z9,Z32,Z32, Y,32'h0FF0F000, N,Z32);
        tbl[22] = mk(Y, Y,N,9'd100,Z32,Z32, N,N,Z9,Z32,Z32, Y,32'h0FF0F000, N,Z32);
        tbl[23] = mk(Y, N,Y,9'd100,Z32,ONES, N,N,Z9,Z32,Z32, Y,32'h0FF0F000, N,Z32);
        tbl[24] = mk(Y, N,N,Z9,Z32,Z32, Y,N,9'd100,Z32,Z32, N,Z32, Y,32'h0FF0F000);

        for (int i = 0; i < 25; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);

        // Random independent traffic, same-address collisions with a write excluded.
        for (int i = 0; i < 1000; i++) begin
            v.rst_n = ($urandom_range(0, 49) != 0);
            v.ce0   = ($urandom_range(0, 3) != 0);
            v.we0   = 1'($urandom_range(0, 1));
            v.a0    = ($urandom_range(0, 3) != 0) ? 9'($urandom_range(0, 31)) : 9'($urandom_range(0, 511));
            v.d0    = $urandom;
            v.wem0  = ($urandom_range(0, 2) == 0) ? ONES : (($urandom_range(0, 9) == 0) ? Z32 : $urandom);
            v.ce1   = ($urandom_range(0, 3) != 0);
            v.we1   = 1'($urandom_range(0, 1));
            v.a1    = ($urandom_range(0, 3) != 0) ? 9'($urandom_range(0, 31)) : 9'($urandom_range(0, 511));
            v.d1    = $urandom;
            v.wem1  = ($urandom_range(0, 2) == 0) ? ONES : (($urandom_range(0, 9) == 0) ? Z32 : $urandom);
            if (v.ce0 && v.ce1 && (v.a0 == v.a1) && (v.we0 || v.we1))
                v.a1 = v.a0 ^ 9'd1;
            v.chk0 = 1'b0; v.exp0 = Z32; v.chk1 = 1'b0; v.exp1 = Z32;
            run_vec(v, $sformatf("rnd%0d", i), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_512x32_dp.md
Name: bram_512x32_dp

Overview:
- True dual-port synchronous SRAM macro model: 512 words x 32 bits, two fully independent read/write ports on one clock.
- Per-bit write mask on each port.
- Leaf storage element tiled by the generated multi-port memory wrappers: banks are stacked horizontally for width and duplicated for extra read ports.
- The wrapper drives each port's CE/A/D/WE/WEM and picks Q one cycle later using registered bank-select bits.

Parameters:
- DATA_WIDTH, 32, word width in bits; also the width of D/WEM/Q.
- ADDR_WIDTH, 9, address width.
- DEPTH, 512, number of words; must equal 2**ADDR_WIDTH.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESETN  input  1  synchronous active-low reset.
- CE0  input  1  port 0 enable.
- A0  input  9  port 0 word address.
- D0  input  32  port 0 write data.
- WE0  input  1  port 0 write enable (valid only with CE0=1).
- WEM0  input  32  port 0 per-bit write mask; 1 = write this bit.
- Q0  output  32  port 0 registered read data.
- CE1, A1, D1, WE1, WEM1, Q1: same as port 0, for port 1.

Behaviour:
- Storage: array mem[0..511] of 32 bits. Contents are not cleared by reset. Simulation initial value is 0.
- Reset: with RESETN=0 at a rising edge:
  - Q0 and Q1 are set to 0.
  - No write is performed on either port, regardless of CE/WE.
  - Reset has priority over every other action in that cycle.
- Idle: CEp=0 means no memory access on port p and Qp holds its previous value. WEp, A, D and WEM are ignored.
- Read (CEp=1, WEp=0): at the edge, Qp <= mem[Ap]. Latency is 1 cycle. Qp then holds until the next enabled access or reset.
- Write (CEp=1, WEp=1): at the edge, mem[Ap] <= (mem[Ap] & ~WEMp) | (Dp & WEMp).
  - Bits with WEM=0 are unchanged.
  - WEM=0 writes nothing, but the port still counts as an enabled access.
- Read-during-write, same port: read-first. At that edge Qp <= mem[Ap] before the write (old data). The new data is visible on a later read.
- Both ports reading, any addresses (including the same one): both return mem contents from before the edge.
- Different addresses, any combination of reads and writes: fully independent, no interaction.
- Same address, one port writes and the other reads: the reader gets old data (read-first). The write completes normally.
- Same address, both ports write:
  - Bits masked by only one port take that port's data.
  - Bits masked by both ports take port 1's data (port 1 wins).
  - Both Q outputs return old data.
- The wrappers treat any same-address collision involving a write as illegal; the model must still behave deterministically as above.
- Address range: all 512 addresses are valid, no wrap logic needed. X/Z on address with CE=1 is not required to be handled.
- Timing: no combinational path from any input to Q0/Q1; Q is purely registered.

Test Plan:
- Reset: drive RESETN=0 for 2 cycles with CE0=CE1=1, WE0=1, A0=5, D0=0xFFFFFFFF, WEM0=all ones -> Q0=Q1=0. A later read of addr 5 returns the prior contents (0), proving the write was suppressed.
- Basic write/read and latency:
  - Port 0 writes 0xDEADBEEF to addr 0x1FF with full mask.
  - Next cycle, port 1 reads 0x1FF -> Q1=0xDEADBEEF one edge after the read; Q1 keeps that value while CE1=0 for 5 cycles.
- Bit mask:
  - Write 0xFFFFFFFF to addr 3.
  - Then write D=0x00000000 with WEM=0x0000FFFF.
  - Then write D=0x12345678 with WEM=0x000000F0.
  - Read addr 3 -> 0xFFFF0070.
- Read-first:
  - addr 7 holds 0xAAAA5555.
  - Port 0 writes 0x11111111 to addr 7 while port 1 reads addr 7 in the same cycle -> Q0=Q1=0xAAAA5555.
  - The next read returns 0x11111111.
- Dual write, same address:
  - Port 0 writes D=0x0F0F0F0F with WEM=0xFFFF0000.
  - Port 1 writes D=0xF0F0F0F0 with WEM=0x00FFFF00.
  - Both target addr 100, which previously held 0.
  - Read -> 0x0FF0F000.
- Independence: 1000 random cycles with independent random CE/WE/A/D/WEM on both ports, excluding same-address collisions -> every Q matches a reference array model with read-first semantics.
